// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, drives instruction memory and
// loads the IF/ID register, absorbing memory wait states, load-use stalls and flushes.
module if_fetch_stage #(
   parameter logic [29:0] RESET_PC = 30'h0000_0C00,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [29:0]      npc,
   input  logic             stall,
   input  logic             flush,
   output logic [29:0]      pc,
   output logic             imem_req,
   output logic [29:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      id_ins,
   output logic [29:0]      id_pc_plus_4,
   output logic             id_valid,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic [29:0]       pc_r;
   logic [31:0]       id_ins_r;
   logic [29:0]       id_pc_plus_4_r;
   logic              id_valid_r;
   logic [CNT_W-1:0]  bubble_cnt_r;
   logic [31:0]       hold_buf_r;

   logic              pc_load_s;
   logic              buf_load_s;
   logic              buf_clear_s;
   logic              load_word_s;
   logic              load_bubble_s;
   logic [31:0]       word_s;

   // Next-state and per-cycle actions; priority is flush > stall > normal in both states.
   always_comb begin
      next_state_s  = state_r;
      pc_load_s     = 1'b0;
      buf_load_s    = 1'b0;
      buf_clear_s   = 1'b0;
      load_word_s   = 1'b0;
      load_bubble_s = 1'b0;
      word_s        = imem_rdata;
      case (state_r)
         FETCH: begin
            if (flush) begin
               pc_load_s     = 1'b1;
               load_bubble_s = 1'b1;
            end else if (stall) begin
               if (imem_ready) begin
                  buf_load_s   = 1'b1;
                  next_state_s = HOLD;
               end else begin
                  next_state_s = FETCH;
               end
            end else if (imem_ready) begin
               load_word_s = 1'b1;
               pc_load_s   = 1'b1;
            end else begin
               load_bubble_s = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_load_s     = 1'b1;
               load_bubble_s = 1'b1;
               buf_clear_s   = 1'b1;
               next_state_s  = FETCH;
            end else if (stall) begin
               next_state_s = HOLD;
            end else begin
               word_s       = hold_buf_r;
               load_word_s  = 1'b1;
               pc_load_s    = 1'b1;
               next_state_s = FETCH;
            end
         end
         default: begin
            next_state_s = FETCH;
         end
      endcase
   end

   // State, PC, hold buffer, IF/ID register and saturating bubble counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= FETCH;
         pc_r           <= RESET_PC;
         id_ins_r       <= 32'h0000_0000;
         id_pc_plus_4_r <= 30'h0000_0000;
         id_valid_r     <= 1'b0;
         bubble_cnt_r   <= {CNT_W{1'b0}};
         hold_buf_r     <= 32'h0000_0000;
      end else begin
         state_r <= next_state_s;
         if (pc_load_s) begin
            pc_r <= npc;
         end
         if (buf_load_s) begin
            hold_buf_r <= imem_rdata;
         end else if (buf_clear_s) begin
            hold_buf_r <= 32'h0000_0000;
         end
         if (load_word_s) begin
            id_ins_r       <= word_s;
            id_valid_r     <= 1'b1;
            id_pc_plus_4_r <= pc_r + 30'd1;
         end else if (load_bubble_s) begin
            id_ins_r   <= 32'h0000_0000;
            id_valid_r <= 1'b0;
         end
         if (load_bubble_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign pc           = pc_r;
   assign imem_req     = (state_r == FETCH) & ~rst;
   assign imem_addr    = pc_r;
   assign id_ins       = id_ins_r;
   assign id_pc_plus_4 = id_pc_plus_4_r;
   assign id_valid     = id_valid_r;
   assign bubble_cnt   = bubble_cnt_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic [29:0] npc;
   logic        stall;
   logic        flush;
   logic [29:0] pc;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] id_ins;
   logic [29:0] id_pc_plus_4;
   logic        id_valid;
   logic [3:0]  bubble_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // behavioural model
   logic [29:0] m_pc;
   logic [31:0] m_ins;
   logic [29:0] m_ppc;
   logic        m_valid;
   logic [3:0]  m_cnt;
   logic        m_hold;
   logic [31:0] m_buf;
   logic        m_rst;

   if_fetch_stage #(.RESET_PC(30'h0000_0C00), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .npc(npc), .stall(stall), .flush(flush),
      .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .id_ins(id_ins), .id_pc_plus_4(id_pc_plus_4), .id_valid(id_valid),
      .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_bubble();
      m_ins   = 32'h0;
      m_valid = 1'b0;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
   endtask

   task automatic m_deliver(input logic [31:0] w, input logic [29:0] n);
      m_ins   = w;
      m_valid = 1'b1;
      m_ppc   = m_pc + 30'd1;
      m_pc    = n;
   endtask

   // drive one cycle of inputs, advance the model by the fetch rules, then step the clock
   task automatic tick(input logic r, input logic s, input logic f, input logic rdy,
                       input logic [31:0] d, input logic [29:0] n);
      rst = r; stall = s; flush = f; imem_ready = rdy; imem_rdata = d; npc = n;
      m_rst = r;
      if (r) begin
         m_pc = 30'h0000_0C00; m_ins = 32'h0; m_ppc = 30'h0; m_valid = 1'b0;
         m_cnt = 4'h0; m_hold = 1'b0; m_buf = 32'h0;
      end else if (f) begin
         m_pc = n; m_hold = 1'b0; m_buf = 32'h0;
         m_bubble();
      end else if (s) begin
         if (!m_hold && rdy) begin
            m_buf  = d;
            m_hold = 1'b1;
         end
      end else if (m_hold) begin
         m_deliver(m_buf, n);
         m_hold = 1'b0;
      end else if (rdy) begin
         m_deliver(d, n);
      end else begin
         m_bubble();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 30'h0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 30'h0);
      n_cmp++; if (pc !== 30'h0000_0C00) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 30'h0000_0C00); end
      n_cmp++; if (id_ins !== 32'h0 || id_valid !== 1'b0 || id_pc_plus_4 !== 30'h0) begin n_err++; $display("FAIL reset_ifid got=%h/%b/%h exp=0/0/0", id_ins, id_valid, id_pc_plus_4); end
      n_cmp++; if (bubble_cnt !== 4'h0 || imem_req !== 1'b0) begin n_err++; $display("FAIL reset_cnt_req got=%h/%b exp=0/0", bubble_cnt, imem_req); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (imem_addr !== m_pc || pc !== m_pc) begin n_err++; $display("FAIL zw_pc%0d got=%h exp=%h", i, pc, m_pc); end
         d = $urandom;
         tick(1'b0, 1'b0, 1'b0, 1'b1, d, m_pc + 30'd1);
         n_cmp++; if (id_ins !== d || id_valid !== 1'b1 || id_pc_plus_4 !== m_ppc) begin n_err++; $display("FAIL zw_ifid%0d got=%h/%b/%h exp=%h/1/%h", i, id_ins, id_valid, id_pc_plus_4, d, m_ppc); end
      end
      n_cmp++; if (id_pc_plus_4 !== 30'h0000_0C04 || bubble_cnt !== 4'h0) begin n_err++; $display("FAIL zw_end got=%h/%h exp=c04/0", id_pc_plus_4, bubble_cnt); end
   endtask

   task automatic test_wait_states();
      logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
         n_cmp++; if (pc !== 30'h0000_0C04 || id_ins !== 32'h0 || id_valid !== 1'b0) begin n_err++; $display("FAIL ws_bubble%0d got=%h/%h/%b exp=c04/0/0", i, pc, id_ins, id_valid); end
      end
      n_cmp++; if (bubble_cnt !== 4'd3) begin n_err++; $display("FAIL ws_cnt got=%0d exp=3", bubble_cnt); end
      d = $urandom;
      tick(1'b0, 1'b0, 1'b0, 1'b1, d, 30'h0000_0C05);
      n_cmp++; if (id_ins !== d || id_pc_plus_4 !== 30'h0000_0C05 || id_valid !== 1'b1) begin n_err++; $display("FAIL ws_load got=%h/%h exp=%h/c05", id_ins, id_pc_plus_4, d); end
   endtask

   task automatic test_stall_hold();
      logic [31:0] ins_before;
      logic [29:0] pc_before;
      logic [29:0] n;
      ins_before = id_ins;
      pc_before  = pc;
      tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h8C08_0004, $urandom);
      tick(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req got=%b exp=0", imem_req); end
      n_cmp++; if (id_ins !== ins_before || pc !== pc_before) begin n_err++; $display("FAIL hold_frozen got=%h/%h exp=%h/%h", id_ins, pc, ins_before, pc_before); end
      n = $urandom;
      tick(1'b0, 1'b0, 1'b0, 1'b0, $urandom, n);
      n_cmp++; if (id_ins !== 32'h8C08_0004 || pc !== n || imem_req !== 1'b1) begin n_err++; $display("FAIL hold_release got=%h/%h/%b exp=8c080004/%h/1", id_ins, pc, imem_req, n); end
   endtask

   task automatic test_flush_hold();
      tick(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL fh_enter got=%b exp=0", imem_req); end
      tick(1'b0, 1'b1, 1'b1, 1'b1, $urandom, 30'h0000_0D00);
      n_cmp++; if (id_valid !== 1'b0 || id_ins !== 32'h0 || pc !== 30'h0000_0D00) begin n_err++; $display("FAIL fh_flush got=%b/%h/%h exp=0/0/d00", id_valid, id_ins, pc); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 30'h0000_0D00) begin n_err++; $display("FAIL fh_fetch got=%b/%h exp=1/d00", imem_req, imem_addr); end
      tick(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      n_cmp++; if (id_valid !== 1'b0 || pc !== 30'h0000_0D00) begin n_err++; $display("FAIL fh_dropped got=%b/%h exp=0/d00", id_valid, pc); end
   endtask

   task automatic test_flush_vs_stall();
      logic [29:0] n;
      n = $urandom;
      tick(1'b0, 1'b1, 1'b1, 1'b1, $urandom, n);
      n_cmp++; if (pc !== n || id_valid !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL fvs got=%h/%b/%b exp=%h/0/1", pc, id_valid, imem_req, n); end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] d;
      tick(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 30'h3FFF_FFFF);
      d = $urandom;
      tick(1'b0, 1'b0, 1'b0, 1'b1, d, 30'h0);
      n_cmp++; if (id_pc_plus_4 !== 30'h0 || id_ins !== d || pc !== 30'h0) begin n_err++; $display("FAIL wrap got=%h/%h exp=0/%h", id_pc_plus_4, id_ins, d); end
   endtask

   task automatic test_saturation();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 30'h0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, ($urandom_range(0, 3) == 0), 1'b0, $urandom, $urandom);
         n_cmp++; if (bubble_cnt !== m_cnt) begin n_err++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, bubble_cnt, m_cnt); end
      end
      n_cmp++; if (bubble_cnt !== 4'hF) begin n_err++; $display("FAIL sat_final got=%0d exp=15", bubble_cnt); end
      tick(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
      n_cmp++; if (pc !== 30'h0000_0C00 || bubble_cnt !== 4'h0 || id_valid !== 1'b0 || id_ins !== 32'h0 || id_pc_plus_4 !== 30'h0) begin n_err++; $display("FAIL sat_reset got=%h/%h/%b/%h/%h", pc, bubble_cnt, id_valid, id_ins, id_pc_plus_4); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 2) != 0), $urandom, $urandom);
         n_cmp++;
         if (pc !== m_pc || imem_addr !== m_pc || imem_req !== (!m_hold && !m_rst) ||
             id_ins !== m_ins || id_valid !== m_valid || id_pc_plus_4 !== m_ppc || bubble_cnt !== m_cnt) begin
            n_err++;
            $display("FAIL rand%0d got pc=%h req=%b ins=%h v=%b ppc=%h cnt=%h exp pc=%h req=%b ins=%h v=%b ppc=%h cnt=%h",
                     i, pc, imem_req, id_ins, id_valid, id_pc_plus_4, bubble_cnt,
                     m_pc, (!m_hold && !m_rst), m_ins, m_valid, m_ppc, m_cnt);
         end
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
      imem_rdata = 32'h0; npc = 30'h0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_flush_hold();
      test_flush_vs_stall();
      test_pc_wrap();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch end of the next-PC path. It holds the architectural PC and drives it to the next-PC calculator and to instruction memory. It accepts the computed next PC back and loads the IF/ID pipeline register. It handles memory wait states, load-use stalls and branch/jump flushes, and counts the bubbles it injects.

Parameters:
RESET_PC, 30'h0000_0C00, word address loaded into pc on reset (byte address 0x0000_3000).
CNT_W, 32, width of the saturating bubble counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
npc  input  30  next word address [31:2] from the next-PC calculator; already selects jump, branch or pc+1
stall  input  1  hazard unit: hold PC and IF/ID (load-use)
flush  input  1  branch taken or jump in ID; squash the instruction being fetched
pc  output  30  current fetch word address [31:2]; registered
imem_req  output  1  fetch request valid
imem_addr  output  30  equals pc whenever imem_req=1
imem_rdata  input  32  instruction word; valid only when imem_ready=1
imem_ready  input  1  imem_rdata holds the word for the current imem_addr this cycle
id_ins  output  32  IF/ID instruction; registered
id_pc_plus_4  output  30  IF/ID pc+1 (word address of pc+4); registered
id_valid  output  1  id_ins is a real instruction (0 = bubble)
bubble_cnt  output  CNT_W  number of cycles IF/ID was loaded with a bubble; saturating

Behaviour:
- Reset values: pc=RESET_PC, id_ins=0, id_pc_plus_4=0, id_valid=0, bubble_cnt=0, hold buffer=0. The FSM resets to FETCH. Reset overrides every other input.
- imem_req = (state==FETCH) & ~rst. imem_addr = pc, combinational.
- FSM states: FETCH (request outstanding) and HOLD (word captured but stalled).
- Priority in every state: rst > flush > stall > normal.
- FETCH, imem_ready=1:
  - flush: pc<=npc; IF/ID loads a bubble. Stay in FETCH.
  - stall: buffer<=imem_rdata; pc and IF/ID unchanged. Go to HOLD.
  - otherwise: id_ins<=imem_rdata, id_valid<=1, id_pc_plus_4<=pc+1, pc<=npc. Stay in FETCH.
- FETCH, imem_ready=0:
  - flush: pc<=npc, retargeting the request next cycle; IF/ID loads a bubble.
  - stall: everything held.
  - otherwise: pc held; IF/ID loads a bubble.
- HOLD (imem_req=0):
  - flush: pc<=npc; buffer discarded; IF/ID loads a bubble. Go to FETCH.
  - stall: stay in HOLD; everything held.
  - otherwise: id_ins<=buffer, id_valid<=1, id_pc_plus_4<=pc+1, pc<=npc. Go to FETCH.
- Bubble means id_ins<=0 (sll $0 NOP), id_valid<=0. id_pc_plus_4 is held.
- bubble_cnt increments on every cycle IF/ID loads a bubble. It stops at all-ones and does not wrap. It is not incremented while stalled and held.
- Flush while stalled: flush wins. The held word is dropped and the IF/ID instruction becomes a bubble.
- pc+1 is 30-bit arithmetic: 30'h3FFF_FFFF+1 wraps to 0.
- npc is sampled only on cycles where pc updates. Zero-wait memory (imem_ready tied 1) gives one instruction per cycle with no HOLD unless stall is asserted.
- Latency: a word returned in cycle N appears on id_ins after edge N+1 (one register).

Test Plan:
- Reset then zero-wait run: rst=1 for 2 cycles, imem_ready=1, npc=pc+1. Required: pc=C00, C01, C02; id_pc_plus_4 lags one cycle (C01, C02); id_valid=1 from the first post-reset edge; bubble_cnt=0.
- Wait states: imem_ready=0 for 3 cycles at pc=C04. Required: pc held at C04; 3 bubbles with id_ins=0; bubble_cnt=3; then the word at C04 loads with id_pc_plus_4=C05.
- Stall with word returned: stall=1 for 2 cycles while imem_rdata=32'h8C08_0004, ready=1. Required: HOLD entered; imem_req=0; IF/ID unchanged. After release, id_ins=8C080004 and pc<=npc.
- Flush during HOLD: stall=1 and flush=1 with npc=30'h0000_0D00. Required: buffer dropped; id_valid=0; pc=D00 next; state FETCH; imem_addr=D00.
- Flush vs stall same cycle in FETCH with ready=1: required flush behaviour (pc<=npc, bubble) and no HOLD entry.
- Saturation: preload by running bubbles with CNT_W=4. Required: bubble_cnt reaches 15 and stays 15. Reset mid-run returns all outputs to their reset values on the next edge.
